cylon_seq: RTL

//  Parametrised LED scan-pattern sequencer: drives a WIDTH-bit front-panel LED bank with
//  one of four visual patterns (1-eye bounce, 2-eye mirror, walk-wrap, bar bounce).

---
 rtl/cylon_seq.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/cylon_seq.sv
// cylon_seq: LED scan-pattern sequencer for a front-panel LED bank.
//
// Four visual patterns advance one position per prescaler tick:
//   mode 0  single eye bouncing end to end
//   mode 1  two eyes mirrored about the centre, crossing in the middle
//   mode 2  single eye walking upwards and wrapping to bit 0
//   mode 3  bar graph (thermometer) bouncing end to end
//
// The prescaler is an MXPRE-bit accumulator advanced by rate+1 per enabled clock.
// Its carry-out is the tick, so the step period is 2^MXPRE/(rate+1) clocks and no
// tick is lost when rate+1 does not divide 2^MXPRE evenly.
//
// Ports
//   clock    in   1       system clock
//   reset_n  in   1       asynchronous active-low reset
//   enable   in   1       1 = run; 0 = hold prescaler, position, mode and q
//   mode     in   2       pattern select (see above)
//   rate     in   MXRATE  prescaler increment minus one (0 = slowest)
//   q        out  WIDTH   registered LED pattern
//   step     out  1       one-clock pulse on every position update
//   sync     out  1       one-clock pulse when the position returns to 0
module cylon_seq #(
  parameter int unsigned WIDTH  = 12,  // number of LEDs, 2..32
  parameter int unsigned MXPRE  = 21,  // prescaler accumulator width
  parameter int unsigned MXRATE = 2    // rate input width
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [MXRATE-1:0] rate,
  output logic [WIDTH-1:0]  q,
  output logic              step,
  output logic              sync
);

  localparam int unsigned PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [PW-1:0] PosLast = PW'(WIDTH - 1);
  localparam logic [PW-1:0] PosPen  = PW'(WIDTH - 2);

  localparam logic [1:0] ModeMirror = 2'd1;
  localparam logic [1:0] ModeWalk   = 2'd2;
  localparam logic [1:0] ModeBar    = 2'd3;

  // Scan direction; only meaningful for the bouncing patterns.
  typedef enum logic {
    DirUp,
    DirDown
  } dir_e;

  // State registers.
  logic [MXPRE-1:0] acc_q, acc_d;
  logic [PW-1:0]    pos_q, pos_d;
  dir_e             dir_q, dir_d;
  logic [1:0]       mode_q, mode_d;
  logic             init_q, init_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             step_q, step_d;
  logic             sync_q, sync_d;

  // Combinational helpers.
  logic [MXPRE:0]   sum;
  logic             tick;
  logic             mode_chg;
  logic [1:0]       mode_cur;
  logic [PW-1:0]    mirror;
  logic [WIDTH-1:0] pat;

  // On the first clock after reset mode_q has not yet captured the input, so the
  // live input is used directly and no mode-change restart is raised.
  always_comb begin
    mode_cur = init_q ? mode : mode_q;
    sum      = {1'b0, acc_q} + (MXPRE + 1)'(rate) + (MXPRE + 1)'(1);
    tick     = enable & sum[MXPRE];
    mode_chg = enable & ~init_q & (mode != mode_q);
  end

  // Next-state logic for prescaler, position and direction.
  always_comb begin
    acc_d  = acc_q;
    pos_d  = pos_q;
    dir_d  = dir_q;
    step_d = 1'b0;
    sync_d = 1'b0;
    init_d = 1'b0;
    // A mode change while frozen is acted on once enable returns.
    mode_d = (enable | init_q) ? mode : mode_q;

    if (mode_chg) begin
      // Restart the new pattern from its origin; this wins over a coincident tick.
      acc_d = '0;
      pos_d = '0;
      dir_d = DirUp;
    end else if (enable) begin
      acc_d = sum[MXPRE-1:0];
      if (tick) begin
        step_d = 1'b1;
        if (mode_cur == ModeWalk) begin
          dir_d = DirUp;
          pos_d = (pos_q == PosLast) ? '0 : pos_q + PW'(1);
        end else begin
          // Bounce without dwelling on either end: period 2*WIDTH-2 ticks.
          unique case (dir_q)
            DirUp: begin
              if (pos_q == PosLast) begin
                pos_d = PosPen;
                dir_d = DirDown;
              end else begin
                pos_d = pos_q + PW'(1);
              end
            end
            DirDown: begin
              if (pos_q == '0) begin
                pos_d = PW'(1);
                dir_d = DirUp;
              end else begin
                pos_d = pos_q - PW'(1);
              end
            end
            default: begin
              pos_d = '0;
              dir_d = DirUp;
            end
          endcase
        end
        sync_d = (pos_d == '0);
      end
    end
  end

  // Pattern decode from the next position so q changes on the same clock as step.
  // It uses the registered mode, so after a mode change the new pattern appears one
  // clock after the restart.
  always_comb begin
    pat    = '0;
    mirror = PosLast - pos_d;
    for (int i = 0; i < WIDTH; i++) begin
      case (mode_cur)
        ModeMirror: pat[i] = (PW'(i) == pos_d) | (PW'(i) == mirror);
        ModeBar:    pat[i] = (PW'(i) <= pos_d);
        default:    pat[i] = (PW'(i) == pos_d);
      endcase
    end
    q_d = enable ? pat : q_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_q  <= '0;
      pos_q  <= '0;
      dir_q  <= DirUp;
      mode_q <= '0;
      init_q <= 1'b1;
      q_q    <= '0;
      step_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      mode_q <= mode_d;
      init_q <= init_d;
      q_q    <= q_d;
      step_q <= step_d;
      sync_q <= sync_d;
    end
  end

  assign q    = q_q;
  assign step = step_q;
  assign sync = sync_q;

endmodule
